// File: rtl/processor_run_controller.sv
// processor_run_controller
//
// Run-control sequencer for single_cycle_processor. It owns the core's
// synchronous reset and per-cycle clock enable, so the core can be held in
// reset, paused, free-run, single-stepped, stopped on a PC breakpoint, or
// halted on the all-zero halt instruction. It also counts the cycles in
// which the core executed, for the debug host.
//
// state | meaning
// ------+-----------------------------------------------------------------
// 0     | RESET_HOLD : cpu_reset asserted, hold timer counting down
// 1     | PAUSED     : core idle; start runs it, step executes one instr
// 2     | RUNNING    : core enabled until stop, halt word or breakpoint
// 3     | HALTED     : halt word reached; only restart leaves this state
//
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   cmd_start/step/stop     one-cycle command pulses from the debug host
//   cmd_restart             one-cycle pulse, re-resets the core from any state
//   bp_enable, bp_address   PC breakpoint compare
//   cpu_pc, cpu_instruction current core PC and the instruction at that PC
//   cpu_reset               registered core reset
//   cpu_enable              combinational core update enable
//   state                   current run state (table above)
//   halt_reason             0 none, 1 halt word, 2 breakpoint, 3 stop command
//   cycle_count             saturating count of enabled edges since core reset

module processor_run_controller #(
  parameter int COUNT_WIDTH  = 32,
  parameter int RESET_CYCLES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_start,
  input  logic                   cmd_step,
  input  logic                   cmd_stop,
  input  logic                   cmd_restart,
  input  logic                   bp_enable,
  input  logic [31:0]            bp_address,
  input  logic [31:0]            cpu_pc,
  input  logic [31:0]            cpu_instruction,
  output logic                   cpu_reset,
  output logic                   cpu_enable,
  output logic [1:0]             state,
  output logic [1:0]             halt_reason,
  output logic [COUNT_WIDTH-1:0] cycle_count
);

  localparam int HOLD_WIDTH = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_WIDTH-1:0] HOLD_LOAD = HOLD_WIDTH'(RESET_CYCLES - 1);

  localparam logic [1:0] REASON_NONE  = 2'd0;
  localparam logic [1:0] REASON_HALT  = 2'd1;
  localparam logic [1:0] REASON_BREAK = 2'd2;
  localparam logic [1:0] REASON_STOP  = 2'd3;

  typedef enum logic [1:0] {
    S_RESET_HOLD = 2'd0,
    S_PAUSED     = 2'd1,
    S_RUNNING    = 2'd2,
    S_HALTED     = 2'd3
  } run_state_t;

  run_state_t            state_q;
  logic [HOLD_WIDTH-1:0] hold_count;
  logic                  skip_bp;
  logic                  halt_hit;
  logic                  bp_hit;
  logic                  do_start;
  logic                  do_step;

  assign halt_hit = (cpu_instruction == 32'h0);
  // skip_bp lets a resumed run execute the instruction it was paused on.
  assign bp_hit   = bp_enable && (cpu_pc == bp_address) && !skip_bp;

  // Priority restart > stop > start > step; losers in the same cycle are dropped.
  assign do_start = cmd_start && !cmd_restart && !cmd_stop;
  assign do_step  = cmd_step && !cmd_restart && !cmd_stop && !cmd_start;

  assign state = state_q;

  // Decoded from the registered state and this cycle's inputs so a command
  // takes effect at the very edge that samples it.
  always_comb begin
    cpu_enable = 1'b0;
    if (!reset && !cmd_restart) begin
      case (state_q)
        S_PAUSED:  cpu_enable = do_step && !halt_hit;
        S_RUNNING: cpu_enable = !(cmd_stop || halt_hit || bp_hit);
        default:   cpu_enable = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset || cmd_restart) begin
      state_q     <= S_RESET_HOLD;
      cpu_reset   <= 1'b1;
      halt_reason <= REASON_NONE;
      cycle_count <= '0;
      hold_count  <= HOLD_LOAD;
      skip_bp     <= 1'b0;
    end else begin
      if (cpu_enable && (cycle_count != '1)) begin
        cycle_count <= cycle_count + COUNT_WIDTH'(1);
      end

      case (state_q)
        S_RESET_HOLD: begin
          if (hold_count == '0) begin
            state_q   <= S_PAUSED;
            cpu_reset <= 1'b0;
          end else begin
            hold_count <= hold_count - HOLD_WIDTH'(1);
          end
        end

        S_PAUSED: begin
          if (do_start) begin
            state_q     <= S_RUNNING;
            skip_bp     <= 1'b1;
            halt_reason <= REASON_NONE;
          end else if (do_step && halt_hit) begin
            state_q     <= S_HALTED;
            halt_reason <= REASON_HALT;
          end
        end

        S_RUNNING: begin
          skip_bp <= 1'b0;
          if (cmd_stop) begin
            state_q     <= S_PAUSED;
            halt_reason <= REASON_STOP;
          end else if (halt_hit) begin
            state_q     <= S_HALTED;
            halt_reason <= REASON_HALT;
          end else if (bp_hit) begin
            state_q     <= S_PAUSED;
            halt_reason <= REASON_BREAK;
          end
        end

        default: begin
          state_q <= S_HALTED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_processor_run_controller.sv
// Directed bench for processor_run_controller. A tiny core model advances
// its PC by 4 on each enabled edge and resets to 0 under cpu_reset; the
// program is five nonzero instructions at 0x0..0x10 and the halt word at 0x14.

module tb_processor_run_controller;

  logic        clock;
  logic        reset;
  logic        cmd_start;
  logic        cmd_step;
  logic        cmd_stop;
  logic        cmd_restart;
  logic        bp_enable;
  logic [31:0] bp_address;
  logic [31:0] cpu_pc;
  logic [31:0] cpu_instruction;
  logic        cpu_reset;
  logic        cpu_enable;
  logic [1:0]  state;
  logic [1:0]  halt_reason;
  logic [31:0] cycle_count;

  int checks = 0;
  int errors = 0;
  int en_edges = 0;
  int base;

  logic [31:0] core_pc = 32'h0;

  processor_run_controller #(
    .COUNT_WIDTH (32),
    .RESET_CYCLES(2)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .cmd_start      (cmd_start),
    .cmd_step       (cmd_step),
    .cmd_stop       (cmd_stop),
    .cmd_restart    (cmd_restart),
    .bp_enable      (bp_enable),
    .bp_address     (bp_address),
    .cpu_pc         (cpu_pc),
    .cpu_instruction(cpu_instruction),
    .cpu_reset      (cpu_reset),
    .cpu_enable     (cpu_enable),
    .state          (state),
    .halt_reason    (halt_reason),
    .cycle_count    (cycle_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (cpu_reset) core_pc <= 32'h0;
    else if (cpu_enable) core_pc <= core_pc + 32'd4;
    if (cpu_enable) en_edges <= en_edges + 1;
  end

  assign cpu_pc          = core_pc;
  assign cpu_instruction = (core_pc < 32'h14) ? 32'h00000013 : 32'h00000000;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_state(input logic [1:0] target, input int budget, input string tag);
    int n;
    n = 0;
    while (state !== target && n < budget) begin
      tick();
      n++;
    end
    check(tag, state, target);
  endtask

  task automatic restart_to_paused(input string tag);
    cmd_restart = 1'b1;
    tick();
    cmd_restart = 1'b0;
    wait_state(2'd1, 10, tag);
  endtask

  initial begin
    reset = 1'b1;
    cmd_start = 1'b0;
    cmd_step = 1'b0;
    cmd_stop = 1'b0;
    cmd_restart = 1'b0;
    bp_enable = 1'b0;
    bp_address = 32'h0;

    // Reset values and hold sequence
    repeat (3) tick();
    check("rst_state", state, 0);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_reason", halt_reason, 0);
    check("rst_count", cycle_count, 0);
    check("rst_enable", cpu_enable, 0);
    reset = 1'b0;
    tick();
    check("hold1_cpu_reset", cpu_reset, 1);
    check("hold1_state", state, 0);
    tick();
    check("hold2_cpu_reset", cpu_reset, 0);
    check("hold2_state", state, 1);
    check("hold2_enable", cpu_enable, 0);
    check("hold2_pc", cpu_pc, 32'h0);

    // Free run to the halt word
    base = en_edges;
    cmd_start = 1'b1;
    #1 check("start_enable_paused", cpu_enable, 0);
    tick();
    cmd_start = 1'b0;
    check("run_state", state, 2);
    wait_state(2'd3, 20, "run_halt_state");
    check("run_enabled_edges", 64'(en_edges - base), 5);
    check("run_count", cycle_count, 5);
    check("run_reason", halt_reason, 1);
    check("run_pc", cpu_pc, 32'h14);
    check("halted_enable", cpu_enable, 0);
    cmd_step = 1'b1;
    #1 check("halted_step_enable", cpu_enable, 0);
    tick();
    cmd_step = 1'b0;
    check("halted_step_state", state, 3);
    check("halted_step_pc", cpu_pc, 32'h14);

    // Restart from HALTED
    cmd_restart = 1'b1;
    #1 check("restart_enable", cpu_enable, 0);
    tick();
    cmd_restart = 1'b0;
    check("restart_state", state, 0);
    check("restart_cpu_reset_e1", cpu_reset, 1);
    check("restart_count", cycle_count, 0);
    check("restart_reason", halt_reason, 0);
    tick();
    check("restart_cpu_reset_e2", cpu_reset, 1);
    check("restart_state_e2", state, 0);
    check("restart_pc", cpu_pc, 32'h0);
    tick();
    check("restart_paused", state, 1);
    check("restart_cpu_reset_low", cpu_reset, 0);

    // Breakpoint at 0x8, then resume past it
    bp_enable = 1'b1;
    bp_address = 32'h8;
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    wait_state(2'd1, 10, "bp_paused_state");
    check("bp_pc", cpu_pc, 32'h8);
    check("bp_count", cycle_count, 2);
    check("bp_reason", halt_reason, 2);
    check("bp_enable_paused", cpu_enable, 0);
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    check("resume_state", state, 2);
    check("resume_reason", halt_reason, 0);
    #1 check("resume_past_bp_enable", cpu_enable, 1);
    wait_state(2'd3, 20, "resume_halt_state");
    check("resume_count", cycle_count, 5);
    check("resume_pc", cpu_pc, 32'h14);
    check("resume_reason_halt", halt_reason, 1);

    // Single steps on consecutive cycles
    restart_to_paused("step_restart_paused");
    bp_enable = 1'b0;
    cmd_step = 1'b1;
    #1 check("step_enable", cpu_enable, 1);
    tick();
    check("step1_pc", cpu_pc, 32'h4);
    check("step1_state", state, 1);
    tick();
    tick();
    cmd_step = 1'b0;
    check("step3_pc", cpu_pc, 32'hC);
    check("step3_count", cycle_count, 3);
    check("step3_state", state, 1);
    bp_enable = 1'b1;
    bp_address = 32'hC;
    cmd_step = 1'b1;
    #1 check("step_ignores_bp", cpu_enable, 1);
    tick();
    cmd_step = 1'b0;
    bp_enable = 1'b0;
    check("step4_pc", cpu_pc, 32'h10);
    check("step4_count", cycle_count, 4);
    cmd_step = 1'b1;
    tick();
    cmd_step = 1'b0;
    check("step5_pc", cpu_pc, 32'h14);
    check("step5_state", state, 1);
    cmd_step = 1'b1;
    #1 check("step_on_halt_enable", cpu_enable, 0);
    tick();
    cmd_step = 1'b0;
    check("step_halt_state", state, 3);
    check("step_halt_reason", halt_reason, 1);
    check("step_halt_pc", cpu_pc, 32'h14);
    check("step_halt_count", cycle_count, 5);

    // Simultaneous commands
    restart_to_paused("sim_restart_paused");
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    tick();
    check("sim_run_pc", cpu_pc, 32'h4);
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    check("start_in_run_state", state, 2);
    check("start_in_run_pc", cpu_pc, 32'h8);
    cmd_stop = 1'b1;
    cmd_start = 1'b1;
    #1 check("stop_start_enable", cpu_enable, 0);
    tick();
    cmd_stop = 1'b0;
    cmd_start = 1'b0;
    check("stop_start_state", state, 1);
    check("stop_start_reason", halt_reason, 3);
    check("stop_start_pc", cpu_pc, 32'h8);
    check("stop_start_count", cycle_count, 2);
    cmd_stop = 1'b1;
    tick();
    cmd_stop = 1'b0;
    check("stop_in_paused_state", state, 1);
    cmd_restart = 1'b1;
    cmd_step = 1'b1;
    #1 check("restart_step_enable", cpu_enable, 0);
    tick();
    cmd_restart = 1'b0;
    cmd_step = 1'b0;
    check("restart_step_state", state, 0);
    check("restart_step_cpu_reset", cpu_reset, 1);
    check("restart_step_pc", cpu_pc, 32'h8);
    check("restart_step_count", cycle_count, 0);
    check("restart_step_reason", halt_reason, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
